// File: rtl/fsm_cmd_pkg.sv
// Shared constants for the zot command stage.
// Optional feature macro: FSM_CMD_AUTO_START_EN.
package fsm_cmd_pkg;

  localparam logic [2:0] ZOT_IDLE = 3'b000;
  localparam logic [2:0] ZOT_S1   = 3'b101;
  localparam logic [2:0] ZOT_S2   = 3'b111;
  localparam logic [2:0] ZOT_S3   = 3'b001;

  // Bits needed to hold 0..maxv, never less than one.
  function automatic int cnt_w(input int maxv);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < (maxv + 1)) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a counter debouncer.
// Part of fsm_cmd_gen (macro FSM_CMD_AUTO_START_EN not used here).
module sync_debounce
  import fsm_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_w(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count cycles the synced input disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CMAX) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser chain and debounce state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= din;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/fsm_cmd_gen.sv
// Command stage for the zot sequencer: start, skip3, wait3.
// Optional macro FSM_CMD_AUTO_START_EN adds periodic auto-start.
module fsm_cmd_gen
  import fsm_cmd_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int WAIT_MAX    = 8,
  parameter int AUTO_PERIOD = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       skip_sw,
  input  logic       wait_sw,
  input  logic [2:0] zot,
  output logic       start,
  output logic       skip3,
  output logic       wait3,
  output logic       wait_timeout
);

  localparam int WW = cnt_w(WAIT_MAX);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);
  localparam logic TO_EN = (WAIT_MAX != 0);

  logic          stb_start;
  logic          stb_skip;
  logic          stb_wait;
  logic          stb_prev_q;
  logic          rise;
  logic          auto_hit;
  logic          evt;
  logic          want;
  logic          issue;
  logic          idle;
  logic          s3;
  logic          pend_q;
  logic          pend_d;
  logic          start_q;
  logic [WW-1:0] wcnt_q;
  logic [WW-1:0] wcnt_d;
  logic          timeout;
  logic          fire;
  logic          fired_q;
  logic          fired_d;
  logic          wto_q;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (start_btn),
    .dout    (stb_start)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_skip (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (skip_sw),
    .dout    (stb_skip)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (wait_sw),
    .dout    (stb_wait)
  );

  assign idle = (zot == ZOT_IDLE);
  assign s3   = (zot == ZOT_S3);
  assign rise = stb_start & ~stb_prev_q;

`ifdef FSM_CMD_AUTO_START_EN
  localparam int AW = cnt_w(AUTO_PERIOD - 1);
  localparam logic [AW-1:0] AMAX = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] icnt_q;
  logic [AW-1:0] icnt_d;

  // Idle counter raises an auto-start request once per period.
  always_comb begin
    icnt_d   = '0;
    auto_hit = 1'b0;
    if (idle && !pend_q) begin
      if (icnt_q == AMAX) begin
        auto_hit = 1'b1;
      end else begin
        icnt_d = icnt_q + AW'(1);
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) icnt_q <= '0;
    else          icnt_q <= icnt_d;
  end
`else
  assign auto_hit = 1'b0;
`endif

  // A request issues when the sequencer is idle; a fresh
  // edge arriving while an older one issues stays pending.
  always_comb begin
    evt    = rise | auto_hit;
    want   = pend_q | evt;
    issue  = want & idle & ~start_q;
    pend_d = (pend_q & evt) | (want & ~issue);
  end

  // Dwell timer in state3, saturating at the limit.
  always_comb begin
    wcnt_d = '0;
    if (s3) begin
      if (wcnt_q != WMAX) wcnt_d = wcnt_q + WW'(1);
      else                wcnt_d = wcnt_q;
    end
    fire = TO_EN & s3 & stb_wait &
           (wcnt_d == WMAX) & ~fired_q;
    fired_d = s3 & (fired_q | fire);
  end

  // Start request, dwell timer and timeout pulse state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      start_q    <= 1'b0;
      wcnt_q     <= '0;
      fired_q    <= 1'b0;
      wto_q      <= 1'b0;
    end else begin
      stb_prev_q <= stb_start;
      pend_q     <= pend_d;
      start_q    <= issue;
      wcnt_q     <= wcnt_d;
      fired_q    <= fired_d;
      wto_q      <= fire;
    end
  end

  assign timeout      = TO_EN & (wcnt_q == WMAX);
  assign start        = start_q;
  assign skip3        = stb_skip;
  assign wait3        = stb_wait & ~timeout;
  assign wait_timeout = wto_q;

endmodule

// File: tb/tb_fsm_cmd_gen.sv
// Directed bench for fsm_cmd_gen (DEB_CYCLES=4, WAIT_MAX=8/0).
// FSM_CMD_AUTO_START_EN enables the auto-start scenario.
module tb_fsm_cmd_gen;

  logic       clk;
  logic       reset_n;
  logic       start_btn;
  logic       skip_sw;
  logic       wait_sw;
  logic [2:0] zot;
  logic       start;
  logic       skip3;
  logic       wait3;
  logic       wait_timeout;
  logic       start0;
  logic       skip30;
  logic       wait30;
  logic       wto0;

  int vecs;
  int miss;

  fsm_cmd_gen #(
    .DEB_CYCLES  (4),
    .WAIT_MAX    (8),
    .AUTO_PERIOD (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_btn    (start_btn),
    .skip_sw      (skip_sw),
    .wait_sw      (wait_sw),
    .zot          (zot),
    .start        (start),
    .skip3        (skip3),
    .wait3        (wait3),
    .wait_timeout (wait_timeout)
  );

  fsm_cmd_gen #(
    .DEB_CYCLES  (4),
    .WAIT_MAX    (0),
    .AUTO_PERIOD (64)
  ) dut0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_btn    (start_btn),
    .skip_sw      (skip_sw),
    .wait_sw      (wait_sw),
    .zot          (zot),
    .start        (start0),
    .skip3        (skip30),
    .wait3        (wait30),
    .wait_timeout (wto0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n   = 1'b0;
    start_btn = 1'b0;
    skip_sw   = 1'b0;
    wait_sw   = 1'b0;
    zot       = 3'b000;
    repeat (3) @(negedge clk);
    vecs++;
    if ({start, skip3, wait3, wait_timeout} !== 4'b0) begin
      miss++;
      $display("FAIL reset_outs got %b want 0000",
               {start, skip3, wait3, wait_timeout});
    end
    reset_n = 1'b1;
    // press while busy so a start is left pending
    zot = 3'b111;
    start_btn = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if ({start, skip3, wait3, wait_timeout} !== 4'b0) begin
      miss++;
      $display("FAIL async_reset got %b want 0000",
               {start, skip3, wait3, wait_timeout});
    end
    start_btn = 1'b0;
    zot = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (start !== 1'b0) begin
        miss++;
        $display("FAIL stale_pending cyc %0d got %b want 0",
                 i, start);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_debounce();
    zot = 3'b000;
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (start !== 1'b0) begin
        miss++;
        $display("FAIL glitch cyc %0d got %b want 0",
                 i, start);
      end
    end
    @(negedge clk);
    start_btn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (start !== (k == 7)) begin
        miss++;
        $display("FAIL press_edge%0d got %b want %b",
                 k, start, (k == 7));
      end
      if (k == 10) start_btn = 1'b0;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_busy_hold();
    int pulses;
    zot = 3'b111;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      start_btn = 1'b1;
      repeat (10) @(negedge clk);
      start_btn = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        vecs++;
        if (start !== 1'b0) begin
          miss++;
          $display("FAIL busy_p%0d cyc %0d got %b want 0",
                   p, i, start);
        end
      end
    end
    @(negedge clk);
    zot = 3'b000;
    @(posedge clk);
    #1;
    vecs++;
    if (start !== 1'b1) begin
      miss++;
      $display("FAIL busy_release got %b want 1", start);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (start === 1'b1) pulses++;
    end
    vecs++;
    if (pulses !== 0) begin
      miss++;
      $display("FAIL coalesce extra pulses %0d want 0",
               pulses);
    end
    @(negedge clk);
  endtask

  task automatic test_skip();
    @(negedge clk);
    skip_sw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (skip3 !== (k >= 6)) begin
        miss++;
        $display("FAIL skip_edge%0d got %b want %b",
                 k, skip3, (k >= 6));
      end
    end
    @(negedge clk);
    skip_sw = 1'b0;
    repeat (8) @(negedge clk);
    vecs++;
    if (skip3 !== 1'b0) begin
      miss++;
      $display("FAIL skip_release got %b want 0", skip3);
    end
  endtask

  task automatic test_timeout();
    zot = 3'b000;
    wait_sw = 1'b1;
    repeat (8) @(negedge clk);
    zot = 3'b001;
    for (int i = 0; i < 12; i++) begin
      vecs++;
      if (wait3 !== (i < 8)) begin
        miss++;
        $display("FAIL wait3_cyc%0d got %b want %b",
                 i, wait3, (i < 8));
      end
      vecs++;
      if (wait_timeout !== (i == 8)) begin
        miss++;
        $display("FAIL wto_cyc%0d got %b want %b",
                 i, wait_timeout, (i == 8));
      end
      @(negedge clk);
    end
    zot = 3'b000;
    @(negedge clk);
    zot = 3'b001;
    #1;
    vecs++;
    if (wait3 !== 1'b1) begin
      miss++;
      $display("FAIL wait3_rearm got %b want 1", wait3);
    end
    @(negedge clk);
    vecs++;
    if (wait3 !== 1'b1 || wait_timeout !== 1'b0) begin
      miss++;
      $display("FAIL rearm_cyc1 got %b%b want 10",
               wait3, wait_timeout);
    end
    zot = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_no_timeout();
    int bad;
    bad = 0;
    zot = 3'b001;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wait30 !== 1'b1 || wto0 !== 1'b0) bad++;
    end
    vecs++;
    if (bad !== 0) begin
      miss++;
      $display("FAIL wmax0 bad cycles %0d want 0", bad);
    end
    zot = 3'b000;
    wait_sw = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_illegal_zot();
    logic [2:0] codes [4];
    codes[0] = 3'b010;
    codes[1] = 3'b011;
    codes[2] = 3'b100;
    codes[3] = 3'b110;
    zot = codes[0];
    start_btn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      zot = codes[c];
      repeat (6) begin
        @(posedge clk);
        #1;
        vecs++;
        if (start !== 1'b0) begin
          miss++;
          $display("FAIL illegal_zot %b got %b want 0",
                   codes[c], start);
        end
      end
    end
    start_btn = 1'b0;
    @(negedge clk);
    zot = 3'b000;
    @(posedge clk);
    #1;
    vecs++;
    if (start !== 1'b1) begin
      miss++;
      $display("FAIL illegal_release got %b want 1", start);
    end
    repeat (10) @(negedge clk);
  endtask

`ifdef FSM_CMD_AUTO_START_EN
  task automatic test_auto_start();
    int last;
    int pulses;
    reset_n = 1'b0;
    zot = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
    last = -1;
    pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (start === 1'b1) begin
        pulses++;
        vecs++;
        if (last >= 0 && (i - last) !== 64) begin
          miss++;
          $display("FAIL auto_gap got %0d want 64",
                   i - last);
        end
        last = i;
      end
    end
    vecs++;
    if (pulses !== 3) begin
      miss++;
      $display("FAIL auto_count got %0d want 3", pulses);
    end
    @(negedge clk);
    zot = 3'b101;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      if (start === 1'b1) pulses++;
    end
    vecs++;
    if (pulses !== 0) begin
      miss++;
      $display("FAIL auto_busy got %0d want 0", pulses);
    end
    zot = 3'b000;
  endtask
`else
  task automatic test_no_auto();
    int pulses;
    zot = 3'b000;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      if (start === 1'b1) pulses++;
    end
    vecs++;
    if (pulses !== 0) begin
      miss++;
      $display("FAIL no_auto got %0d want 0", pulses);
    end
  endtask
`endif

  initial begin
    vecs = 0;
    miss = 0;
    test_reset();
    test_debounce();
    test_busy_hold();
    test_skip();
    test_timeout();
    test_no_timeout();
    test_illegal_zot();
`ifdef FSM_CMD_AUTO_START_EN
    test_auto_start();
`else
    test_no_auto();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
